// File: rtl/framebuffer_write_arbiter.sv
// Two-channel write-port arbiter for the framebuffer BRAM.
// Round-robin grant with burst preemption and a registered write port.
module framebuffer_write_arbiter #(
    parameter int FBUF_ADDR_WIDTH = 19,
    parameter int FBUF_DATA_WIDTH = 8,
    parameter int MAX_BURST       = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ch0_req,
    output logic                       ch0_gnt,
    input  logic                       ch0_fbuf_en_wr,
    input  logic                       ch0_fbuf_wrea,
    input  logic [FBUF_ADDR_WIDTH-1:0] ch0_fbuf_addr,
    input  logic [FBUF_DATA_WIDTH-1:0] ch0_fbuf_data,
    input  logic                       ch0_fbuf_rst_req_n,
    input  logic                       ch1_req,
    output logic                       ch1_gnt,
    input  logic                       ch1_fbuf_en_wr,
    input  logic                       ch1_fbuf_wrea,
    input  logic [FBUF_ADDR_WIDTH-1:0] ch1_fbuf_addr,
    input  logic [FBUF_DATA_WIDTH-1:0] ch1_fbuf_data,
    input  logic                       ch1_fbuf_rst_req_n,
    output logic                       fbuf_en_wr,
    output logic                       fbuf_wrea,
    output logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr,
    output logic [FBUF_DATA_WIDTH-1:0] fbuf_data,
    output logic                       fbuf_rst_req_n,
    output logic                       fbuf_sel,
    output logic                       busy
);

    localparam int CW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t          state_q, state_d;
    logic            last_owner_q, last_owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   cnt_inc;
    logic            beat;
    logic            burst_done;

    logic                       en_wr_q, en_wr_d;
    logic                       wrea_q, wrea_d;
    logic [FBUF_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [FBUF_DATA_WIDTH-1:0] data_q, data_d;
    logic                       rst_req_n_q, rst_req_n_d;
    logic                       sel_q, sel_d;

    // Counter includes the beat of the current cycle when deciding preemption.
    always_comb begin
        beat = ((state_q == OWN0) && ch0_fbuf_en_wr)
            || ((state_q == OWN1) && ch1_fbuf_en_wr);
        cnt_inc = cnt_q;
        if (beat && (cnt_q != CNT_MAX)) begin
            cnt_inc = cnt_q + 1'b1;
        end
        burst_done = (MAX_BURST != 0) && (cnt_inc == CNT_MAX);
    end

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (ch0_req && ch1_req) begin
                    state_d = last_owner_q ? OWN0 : OWN1;
                end else if (ch0_req) begin
                    state_d = OWN0;
                end else if (ch1_req) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                cnt_d = cnt_inc;
                if (!ch0_req || (ch1_req && burst_done)) begin
                    state_d      = ch1_req ? OWN1 : IDLE;
                    last_owner_d = 1'b0;
                    cnt_d        = '0;
                end
            end
            OWN1: begin
                cnt_d = cnt_inc;
                if (!ch1_req || (ch0_req && burst_done)) begin
                    state_d      = ch0_req ? OWN0 : IDLE;
                    last_owner_d = 1'b1;
                    cnt_d        = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        en_wr_d     = 1'b0;
        wrea_d      = 1'b0;
        rst_req_n_d = 1'b1;
        addr_d      = addr_q;
        data_d      = data_q;
        sel_d       = sel_q;
        if (state_q == OWN0) begin
            en_wr_d     = ch0_fbuf_en_wr;
            wrea_d      = ch0_fbuf_en_wr & ch0_fbuf_wrea;
            addr_d      = ch0_fbuf_addr;
            data_d      = ch0_fbuf_data;
            rst_req_n_d = ch0_fbuf_rst_req_n;
            sel_d       = 1'b0;
        end else if (state_q == OWN1) begin
            en_wr_d     = ch1_fbuf_en_wr;
            wrea_d      = ch1_fbuf_en_wr & ch1_fbuf_wrea;
            addr_d      = ch1_fbuf_addr;
            data_d      = ch1_fbuf_data;
            rst_req_n_d = ch1_fbuf_rst_req_n;
            sel_d       = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            cnt_q        <= '0;
            en_wr_q      <= 1'b0;
            wrea_q       <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            rst_req_n_q  <= 1'b1;
            sel_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            en_wr_q      <= en_wr_d;
            wrea_q       <= wrea_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            rst_req_n_q  <= rst_req_n_d;
            sel_q        <= sel_d;
        end
    end

    assign ch0_gnt        = (state_q == OWN0);
    assign ch1_gnt        = (state_q == OWN1);
    assign busy           = (state_q != IDLE);
    assign fbuf_en_wr     = en_wr_q;
    assign fbuf_wrea      = wrea_q;
    assign fbuf_addr      = addr_q;
    assign fbuf_data      = data_q;
    assign fbuf_rst_req_n = rst_req_n_q;
    assign fbuf_sel       = sel_q;

endmodule
